// File: rtl/ahb_mem_slave.sv
`default_nettype none
// ============================================================================
// Module   : ahb_mem_slave
// Brief    : AHB word memory slave serving the rotation DMA master. Pipelined
//            address/data phases, optional NONSEQ wait states, and a
//            two-cycle ERROR response for illegal accesses.
// Options  : define AHB_MEM_WAIT_EN to honour WAIT_CYCLES (WAIT state and
//            counter present); without it every legal transfer is zero-wait.
// Revision : 1.0 - initial release
// ============================================================================
module ahb_mem_slave #(
  parameter int DEPTH       = 4096,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        I_HCLK,
  input  logic        I_HRESET,
  input  logic        I_MEM_HSEL,
  input  logic [31:0] I_MEM_HADDR,
  input  logic [1:0]  I_MEM_HTRANS,
  input  logic        I_MEM_HWRITE,
  input  logic [2:0]  I_MEM_HSIZE,
  input  logic [2:0]  I_MEM_HBURST,
  input  logic [31:0] I_MEM_HWDATA,
  input  logic        I_MEM_HREADY,
  output logic [31:0] O_MEM_HRDATA,
  output logic        O_MEM_HREADYOUT,
  output logic [1:0]  O_MEM_HRESP
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int ABITS = $clog2(4 * DEPTH);
`ifdef AHB_MEM_WAIT_EN
  localparam bit WAIT_BUILD = 1'b1;
`else
  localparam bit WAIT_BUILD = 1'b0;
`endif
  // NONSEQ beats stall only when the wait feature is built and configured
  localparam bit NONSEQ_WAITS = WAIT_BUILD && (WAIT_CYCLES != 0);

`ifdef AHB_MEM_WAIT_EN
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_WAIT = 3'd1, S_DATA = 3'd2, S_ERR1 = 3'd3, S_ERR2 = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_DATA = 3'd2, S_ERR1 = 3'd3, S_ERR2 = 3'd4
  } state_t;
`endif

  state_t           state;
  state_t           state_next;
  logic [IDX_W-1:0] idx_q;
  logic [1:0]       lo_q;
  logic [1:0]       size_q;
  logic             write_q;
  logic [3:0]       lane_en;
  logic [31:0]      mem [DEPTH];

  logic accept;
  logic can_accept;
  logic take;
  logic addr_bad;
  logic size_bad;
  logic align_bad;
  logic illegal;
  logic unused_burst;

  // Every beat carries its own address, so the burst type is not needed
  assign unused_burst = ^I_MEM_HBURST;

  assign accept     = I_MEM_HSEL & I_MEM_HREADY & I_MEM_HTRANS[1];
  // Only cycles that show HREADYOUT=1 can end a data phase and take a new one
  assign can_accept = (state == S_IDLE) || (state == S_DATA) || (state == S_ERR2);
  assign take       = accept & can_accept;

  // Out-of-range covers both stray high bits and a non power-of-two DEPTH
  assign addr_bad  = ((I_MEM_HADDR >> ABITS) != 32'd0) ||
                     ({2'b00, I_MEM_HADDR[31:2]} >= 32'(DEPTH));
  assign size_bad  = I_MEM_HSIZE[2] | (I_MEM_HSIZE[1] & I_MEM_HSIZE[0]);
  assign align_bad = ((I_MEM_HSIZE == 3'b001) && I_MEM_HADDR[0]) ||
                     ((I_MEM_HSIZE == 3'b010) && (I_MEM_HADDR[1:0] != 2'b00));
  assign illegal   = addr_bad | size_bad | align_bad;

  // State register and address-phase capture
  always_ff @(posedge I_HCLK) begin
    if (I_HRESET) begin
      state   <= S_IDLE;
      idx_q   <= '0;
      lo_q    <= 2'b00;
      size_q  <= 2'b00;
      write_q <= 1'b0;
    end else begin
      state <= state_next;
      if (take) begin
        idx_q   <= I_MEM_HADDR[IDX_W+1:2];
        lo_q    <= I_MEM_HADDR[1:0];
        size_q  <= I_MEM_HSIZE[1:0];
        write_q <= I_MEM_HWRITE;
      end
    end
  end

`ifdef AHB_MEM_WAIT_EN
  logic [2:0] cnt;
  logic [2:0] cnt_next;

  // Wait-state down-counter
  always_ff @(posedge I_HCLK) begin
    if (I_HRESET) cnt <= 3'd0;
    else          cnt <= cnt_next;
  end
`endif

  // Byte lanes touched by the latched transfer (little-endian)
  always_comb begin
    lane_en = 4'b1111;
    case (size_q)
      2'b00:   lane_en = 4'b0001 << lo_q;
      2'b01:   lane_en = lo_q[1] ? 4'b1100 : 4'b0011;
      default: lane_en = 4'b1111;
    endcase
  end

  // Write lands on the completing DATA edge; reset drops it
  always_ff @(posedge I_HCLK) begin
    if (!I_HRESET && (state == S_DATA) && write_q) begin
      for (int b = 0; b < 4; b++) begin
        if (lane_en[b]) mem[idx_q][8*b +: 8] <= I_MEM_HWDATA[8*b +: 8];
      end
    end
  end

  // Next-state decode and bus response outputs
  always_comb begin
    state_next      = S_IDLE;
`ifdef AHB_MEM_WAIT_EN
    cnt_next        = cnt;
`endif
    O_MEM_HREADYOUT = 1'b1;
    O_MEM_HRESP     = 2'b00;
    O_MEM_HRDATA    = 32'd0;
    case (state)
`ifdef AHB_MEM_WAIT_EN
      S_WAIT: begin
        O_MEM_HREADYOUT = 1'b0;
        if (cnt == 3'd0) begin
          state_next = S_DATA;
        end else begin
          state_next = S_WAIT;
          cnt_next   = cnt - 3'd1;
        end
      end
`endif
      S_ERR1: begin
        O_MEM_HREADYOUT = 1'b0;
        O_MEM_HRESP     = 2'b01;
        state_next      = S_ERR2;
      end
      default: begin
        // IDLE, DATA and ERR2 all end with HREADYOUT=1 and may take a new phase
        if (state == S_ERR2) O_MEM_HRESP = 2'b01;
        if ((state == S_DATA) && !write_q) O_MEM_HRDATA = mem[idx_q];
        if (take) begin
          if (illegal) begin
            state_next = S_ERR1;
          end else if (NONSEQ_WAITS && !I_MEM_HTRANS[0]) begin
`ifdef AHB_MEM_WAIT_EN
            state_next = S_WAIT;
            cnt_next   = 3'(WAIT_CYCLES - 1);
`else
            state_next = S_DATA;
`endif
          end else begin
            state_next = S_DATA;
          end
        end
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_ahb_mem_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_ahb_mem_slave
// Brief    : Self-checking bench for ahb_mem_slave. Transfers are queued and
//            driven through a pipelined AHB driver; every data-phase cycle is
//            compared with a word-array reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ahb_mem_slave;

  localparam int DEPTH       = 256;
  localparam int WAIT_CYCLES = 1;
`ifdef AHB_MEM_WAIT_EN
  localparam int WEFF = WAIT_CYCLES;
`else
  localparam int WEFF = 0;
`endif
  localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NS = 2'b10, T_SEQ = 2'b11;

  typedef struct {
    logic        sel;
    logic [1:0]  trans;
    logic        wr;
    logic [2:0]  size;
    logic [2:0]  burst;
    logic [31:0] addr;
    logic [31:0] wdata;
  } xfer_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [31:0] hwdata;
  logic        hready;
  logic [31:0] hrdata;
  logic        hreadyout;
  logic [1:0]  hresp;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] last_rdata;
  xfer_t       list[$];
  logic [31:0] mdl   [DEPTH];
  bit          known [DEPTH];

  assign hready = hreadyout;

  always #5 clk = ~clk;

  ahb_mem_slave #(.DEPTH(DEPTH), .WAIT_CYCLES(WAIT_CYCLES)) dut (
    .I_HCLK          (clk),
    .I_HRESET        (rst),
    .I_MEM_HSEL      (sel),
    .I_MEM_HADDR     (haddr),
    .I_MEM_HTRANS    (htrans),
    .I_MEM_HWRITE    (hwrite),
    .I_MEM_HSIZE     (hsize),
    .I_MEM_HBURST    (hburst),
    .I_MEM_HWDATA    (hwdata),
    .I_MEM_HREADY    (hready),
    .O_MEM_HRDATA    (hrdata),
    .O_MEM_HREADYOUT (hreadyout),
    .O_MEM_HRESP     (hresp)
  );

  function automatic xfer_t mk(logic s, logic [1:0] tr, logic w, logic [2:0] sz,
                               logic [2:0] b, logic [31:0] a, logic [31:0] d);
    xfer_t x;
    x.sel = s; x.trans = tr; x.wr = w; x.size = sz; x.burst = b; x.addr = a; x.wdata = d;
    return x;
  endfunction

  function automatic bit is_legal(logic [31:0] a, logic [2:0] sz);
    if (a >= 32'(4 * DEPTH)) return 1'b0;
    if (sz > 3'd2) return 1'b0;
    if (sz == 3'd1 && a[0]) return 1'b0;
    if (sz == 3'd2 && a[1:0] != 2'b00) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void model_write(logic [31:0] a, logic [2:0] sz, logic [31:0] d);
    int w  = int'(a >> 2);
    int ln = int'(a[1:0]);
    if (sz == 3'd2) begin
      mdl[w]   = d;
      known[w] = 1'b1;
    end else if (sz == 3'd1) begin
      mdl[w][16*(ln/2) +: 16] = d[16*(ln/2) +: 16];
    end else begin
      mdl[w][8*ln +: 8] = d[8*ln +: 8];
    end
  endfunction

  task automatic drive_addr(int idx);
    if (idx < list.size()) begin
      sel    = list[idx].sel;
      htrans = list[idx].trans;
      hwrite = list[idx].wr;
      hsize  = list[idx].size;
      hburst = list[idx].burst;
      haddr  = list[idx].addr;
    end else begin
      sel    = 1'b1;
      htrans = T_IDLE;
      hwrite = 1'($urandom);
      hsize  = 3'd2;
      hburst = 3'd0;
      haddr  = $urandom;
    end
  endtask

  // Drive the queued transfers as an AHB master and check every cycle
  task automatic run_list(output int ncyc);
    xfer_t       cur;
    bit          cur_v = 1'b0;
    int          c = 0;
    int          idx = 0;
    int          budget;
    int          waits;
    int          w;
    logic        rdy;
    bit          legal, last, is_rd, rd_chk;
    logic [31:0] exp_rd;
    budget     = list.size() * 12 + 20;
    ncyc       = 0;
    last_rdata = 'x;
    drive_addr(idx);
    hwdata = $urandom;
    while (idx < list.size() || cur_v) begin
      @(negedge clk);
      ncyc++;
      rdy = hreadyout;
      if (cur_v) begin
        legal  = is_legal(cur.addr, cur.size);
        waits  = !legal ? 1 : ((cur.trans == T_NS) ? WEFF : 0);
        last   = (c >= waits);
        is_rd  = legal && !cur.wr && last;
        w      = int'(cur.addr >> 2);
        rd_chk = !is_rd || known[w];
        exp_rd = is_rd ? mdl[w] : 32'd0;
        checks++;
        if (rdy !== last || hresp !== (legal ? 2'b00 : 2'b01) ||
            (rd_chk && hrdata !== exp_rd)) begin
          failures++;
          $display("FAIL dphase addr=%h wr=%b sz=%0d c=%0d: got rdy=%b resp=%b rdata=%h, want rdy=%b resp=%b rdata=%h",
                   cur.addr, cur.wr, cur.size, c, rdy, hresp, hrdata, last,
                   legal ? 2'b00 : 2'b01, exp_rd);
        end
        if (rdy === 1'b1) begin
          if (legal && cur.wr) model_write(cur.addr, cur.size, cur.wdata);
          if (is_rd) last_rdata = hrdata;
        end
      end else begin
        checks++;
        if (rdy !== 1'b1 || hresp !== 2'b00 || hrdata !== 32'd0) begin
          failures++;
          $display("FAIL idle_cycle: got rdy=%b resp=%b rdata=%h, want rdy=1 resp=00 rdata=0",
                   rdy, hresp, hrdata);
        end
      end
      @(posedge clk);
      if (rdy === 1'b1) begin
        cur_v = 1'b0;
        if (idx < list.size()) begin
          if (list[idx].sel && list[idx].trans[1]) begin
            cur   = list[idx];
            cur_v = 1'b1;
            c     = 0;
          end
          idx++;
        end
      end else begin
        c++;
      end
      #1;
      drive_addr(idx);
      hwdata = cur_v ? cur.wdata : $urandom;
      if (ncyc >= budget) begin
        checks++;
        failures++;
        $display("FAIL cycle_budget: got %0d cycles without finishing, want < %0d", ncyc, budget);
        break;
      end
    end
    list.delete();
  endtask

  task automatic test_reset;
    rst = 1'b1;
    list.delete();
    drive_addr(0);
    hwdata = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (hreadyout !== 1'b1 || hresp !== 2'b00 || hrdata !== 32'd0) begin
      failures++;
      $display("FAIL reset_hold: got rdy=%b resp=%b rdata=%h, want 1 00 0", hreadyout, hresp, hrdata);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (hreadyout !== 1'b1 || hresp !== 2'b00 || hrdata !== 32'd0) begin
      failures++;
      $display("FAIL reset_release: got rdy=%b resp=%b rdata=%h, want 1 00 0", hreadyout, hresp, hrdata);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_word_rw;
    int n;
    list.push_back(mk(1, T_NS, 1, 3'd2, 3'd0, 32'h10, 32'hDEADBEEF));
    run_list(n);
    checks++;
    if (n != 2 + WEFF) begin
      failures++;
      $display("FAIL wr_latency: got %0d cycles, want %0d", n, 2 + WEFF);
    end
    list.push_back(mk(1, T_NS, 0, 3'd2, 3'd0, 32'h10, $urandom));
    run_list(n);
    checks++;
    if (n != 2 + WEFF) begin
      failures++;
      $display("FAIL rd_latency: got %0d cycles, want %0d", n, 2 + WEFF);
    end
    checks++;
    if (last_rdata !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL word_read: got %h, want deadbeef", last_rdata);
    end
  endtask

  task automatic test_lanes;
    int n;
    logic [31:0] d1, d2;
    d1 = $urandom; d1[15:8]  = 8'hAA;
    d2 = $urandom; d2[31:16] = 16'hBBCC;
    list.push_back(mk(1, T_NS, 1, 3'd2, 3'd0, 32'h0, 32'h11223344));
    list.push_back(mk(1, T_NS, 1, 3'd0, 3'd0, 32'h1, d1));
    list.push_back(mk(1, T_NS, 1, 3'd1, 3'd0, 32'h2, d2));
    list.push_back(mk(1, T_NS, 0, 3'd2, 3'd0, 32'h0, $urandom));
    run_list(n);
    checks++;
    if (last_rdata !== 32'hBBCCAA44) begin
      failures++;
      $display("FAIL lanes: got %h, want bbccaa44", last_rdata);
    end
  endtask

  task automatic test_burst;
    int n;
    for (int i = 0; i < 4; i++)
      list.push_back(mk(1, (i == 0) ? T_NS : T_SEQ, 1, 3'd2, 3'd3, 32'(32'h20 + 4 * i), $urandom));
    run_list(n);
    for (int i = 0; i < 4; i++)
      list.push_back(mk(1, (i == 0) ? T_NS : T_SEQ, 0, 3'd2, 3'd3, 32'(32'h20 + 4 * i), $urandom));
    run_list(n);
    checks++;
    if (n != 5 + WEFF) begin
      failures++;
      $display("FAIL burst_cycles: got %0d cycles, want %0d", n, 5 + WEFF);
    end
  endtask

  task automatic test_busy;
    int n;
    list.push_back(mk(1, T_NS,   0, 3'd2, 3'd3, 32'h20, $urandom));
    list.push_back(mk(1, T_BUSY, 0, 3'd2, 3'd3, 32'h24, $urandom));
    list.push_back(mk(1, T_SEQ,  0, 3'd2, 3'd3, 32'h24, $urandom));
    list.push_back(mk(1, T_SEQ,  0, 3'd2, 3'd3, 32'h28, $urandom));
    run_list(n);
    checks++;
    if (n != 5 + WEFF) begin
      failures++;
      $display("FAIL busy_cycles: got %0d cycles, want %0d", n, 5 + WEFF);
    end
  endtask

  task automatic test_errors;
    int n;
    list.push_back(mk(1, T_NS, 1, 3'd2, 3'd0, 32'h2, 32'hFFFFFFFF));
    run_list(n);
    checks++;
    if (n != 3) begin
      failures++;
      $display("FAIL err_cycles: got %0d cycles, want 3", n);
    end
    list.push_back(mk(1, T_NS, 0, 3'd2, 3'd0, 32'(4 * DEPTH), $urandom));
    list.push_back(mk(1, T_NS, 0, 3'd3, 3'd0, 32'h8, $urandom));
    list.push_back(mk(1, T_NS, 1, 3'd1, 3'd0, 32'h1, 32'hFFFFFFFF));
    list.push_back(mk(1, T_NS, 1, 3'd2, 3'd0, 32'(4 * DEPTH), 32'hFFFFFFFF));
    list.push_back(mk(1, T_NS, 0, 3'd2, 3'd0, 32'h0, $urandom));
    run_list(n);
    checks++;
    if (last_rdata !== 32'hBBCCAA44) begin
      failures++;
      $display("FAIL err_no_write: got %h, want bbccaa44", last_rdata);
    end
  endtask

  task automatic test_back_to_back;
    int n;
    list.push_back(mk(1, T_NS, 1, 3'd2, 3'd0, 32'h40, 32'h5A5A5A5A));
    list.push_back(mk(1, T_NS, 0, 3'd2, 3'd0, 32'h40, $urandom));
    run_list(n);
    checks++;
    if (last_rdata !== 32'h5A5A5A5A || n != 3 + 2 * WEFF) begin
      failures++;
      $display("FAIL raw: got data=%h cycles=%0d, want data=5a5a5a5a cycles=%0d",
               last_rdata, n, 3 + 2 * WEFF);
    end
  endtask

  task automatic test_reset_mid;
    int n;
    logic [31:0] oldv = 32'h0BADF00D;
    list.push_back(mk(1, T_NS, 1, 3'd2, 3'd0, 32'h80, oldv));
    run_list(n);
`ifdef AHB_MEM_WAIT_EN
    sel = 1'b1; htrans = T_NS; hwrite = 1'b1; hsize = 3'd2; haddr = 32'h80;
    @(posedge clk); #1;
    drive_addr(0);
    hwdata = 32'h12345678;
    @(negedge clk);
    checks++;
    if (hreadyout !== 1'b0) begin
      failures++;
      $display("FAIL mid_wait_stall: got rdy=%b, want 0", hreadyout);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (hreadyout !== 1'b1 || hresp !== 2'b00 || hrdata !== 32'd0) begin
      failures++;
      $display("FAIL wait_reset: got rdy=%b resp=%b rdata=%h, want 1 00 0", hreadyout, hresp, hrdata);
    end
    @(posedge clk); #1;
`endif
    sel = 1'b1; htrans = T_NS; hwrite = 1'b1; hsize = 3'd3; haddr = 32'h80;
    @(posedge clk); #1;
    drive_addr(0);
    hwdata = 32'h87654321;
    @(negedge clk);
    checks++;
    if (hreadyout !== 1'b0 || hresp !== 2'b01) begin
      failures++;
      $display("FAIL mid_err1: got rdy=%b resp=%b, want 0 01", hreadyout, hresp);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (hreadyout !== 1'b1 || hresp !== 2'b00 || hrdata !== 32'd0) begin
      failures++;
      $display("FAIL err_reset: got rdy=%b resp=%b rdata=%h, want 1 00 0", hreadyout, hresp, hrdata);
    end
    @(posedge clk); #1;
    list.push_back(mk(1, T_NS, 0, 3'd2, 3'd0, 32'h80, $urandom));
    run_list(n);
    checks++;
    if (last_rdata !== oldv) begin
      failures++;
      $display("FAIL dropped_write: got %h, want %h", last_rdata, oldv);
    end
  endtask

  task automatic test_random;
    int n, r, e;
    logic [1:0]  tr;
    logic [2:0]  sz;
    logic [31:0] a;
    for (int i = 0; i < 64; i++)
      list.push_back(mk(1, (i == 0) ? T_NS : T_SEQ, 1, 3'd2, 3'd1, 32'(i * 4), $urandom));
    run_list(n);
    for (int i = 0; i < 250; i++) begin
      r  = int'($urandom_range(0, 99));
      tr = (r < 55) ? T_NS : (r < 80) ? T_SEQ : (r < 90) ? T_BUSY : T_IDLE;
      sz = 3'($urandom_range(0, 2));
      a  = 32'($urandom_range(0, 63)) * 32'd4;
      if (sz == 3'd0) a = a + 32'($urandom_range(0, 3));
      if (sz == 3'd1) a = a + 32'd2 * 32'($urandom_range(0, 1));
      e = int'($urandom_range(0, 19));
      if (e == 0) sz = 3'($urandom_range(3, 7));
      if (e == 1) a = a + 32'($urandom_range(1, 3));
      if (e == 2) a = a | (32'd1 << $urandom_range(10, 31));
      list.push_back(mk(1'($urandom_range(0, 9) != 0), tr, 1'($urandom), sz,
                        3'($urandom), a, $urandom));
    end
    run_list(n);
    for (int i = 0; i < 64; i += 4)
      list.push_back(mk(1, T_NS, 0, 3'd2, 3'd0, 32'(i * 4), $urandom));
    run_list(n);
  endtask

  initial begin
    test_reset();
    test_word_rw();
    test_lanes();
    test_burst();
    test_busy();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached before the summary");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
